// File: rtl/ppu_pkg.sv
// ppu_pkg: shared PPU table constants, host fence addresses and write-buffer types.
package ppu_pkg;
    localparam logic [3:0] TBL_ATTR    = 4'h0;
    localparam logic [3:0] TBL_COLOR   = 4'h1;
    localparam logic [3:0] TBL_PATTERN = 4'h2;
    localparam logic [3:0] TBL_SPRITE  = 4'h3;
    localparam logic [15:0] COMMIT_ADDR  = 16'hFFFF;
    localparam logic [15:0] IRQ_CLR_ADDR = 16'hFFFE;
    localparam int VACTIVE = 480;
    typedef struct packed {
        logic [15:0] addr;
        logic [31:0] data;
    } wbuf_entry_t;
    typedef enum logic [1:0] {IDLE, WAIT_VB, DRAIN} wbuf_state_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with occupancy count; caller must not push when full or pop when empty.
module sync_fifo #(
    parameter int W     = 48,
    parameter int DEPTH = 64
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      push,
    input  logic                      pop,
    input  logic [W-1:0]              din,
    output logic [W-1:0]              dout,
    output logic                      full,
    output logic                      empty,
    output logic [$clog2(DEPTH):0]    count
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];
    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PW:0]   count_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= din;
    end
    assign dout  = mem_q[rd_ptr_q];
    assign full  = count_q == FULL_CNT;
    assign empty = count_q == '0;
    assign count = count_q;
endmodule

// File: rtl/vblank_write_buffer.sv
// vblank_write_buffer: stages host table writes and releases committed batches to the PPU only in vblank.
// Optional irq output (set on frame_done, cleared by a host write to COMMIT_ADDR-1) under VBLANK_WBUF_IRQ_EN.
module vblank_write_buffer #(
    parameter int DEPTH = 64,
    parameter int AW    = 16,
    parameter int DW    = 32,
    parameter int VACTIVE = ppu_pkg::VACTIVE,
    parameter logic [AW-1:0] COMMIT_ADDR = AW'(ppu_pkg::COMMIT_ADDR)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    chipselect,
    input  logic                    write,
    input  logic [AW-1:0]           address,
    input  logic [DW-1:0]           writedata,
    output logic                    waitrequest,
    input  logic [9:0]              vcount,
    output logic                    wr_en,
    output logic [AW-1:0]           wr_addr,
    output logic [DW-1:0]           wr_data,
    output logic [$clog2(DEPTH):0]  pending,
    output logic                    frame_done
`ifdef VBLANK_WBUF_IRQ_EN
    ,
    output logic                    irq
`endif
);
    import ppu_pkg::*;
    localparam int CW = $clog2(DEPTH) + 1;
    wbuf_state_t   state_q, state_d;
    logic [CW-1:0] pending_q, pending_d, count;
    logic [AW+DW-1:0] dout;
    logic full, empty, vblank, acc, commit, clr, push, pop;
    logic frame_done_q, frame_done_d, wr_en_q;
    logic [AW-1:0] wr_addr_q;
    logic [DW-1:0] wr_data_q;
    assign vblank      = vcount >= 10'(VACTIVE);
    assign waitrequest = chipselect & write & full & (address != COMMIT_ADDR);
    assign acc         = chipselect & write & ~waitrequest;
    assign commit      = acc & (address == COMMIT_ADDR);
`ifdef VBLANK_WBUF_IRQ_EN
    localparam logic [AW-1:0] CLR_ADDR = COMMIT_ADDR - AW'(1);
    logic irq_q;
    assign clr = acc & (address == CLR_ADDR);
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) irq_q <= 1'b0;
        else if (frame_done_q) irq_q <= 1'b1;
        else if (clr) irq_q <= 1'b0;
    end
    assign irq = irq_q;
`else
    assign clr = 1'b0;
`endif
    assign push = acc & ~commit & ~clr;
    assign pop  = (state_q == DRAIN) & vblank & (pending_q != '0);
    sync_fifo #(.W(AW + DW), .DEPTH(DEPTH)) u_fifo (
        .clk(clk), .rst_n(reset_n), .push(push), .pop(pop), .din({address, writedata}),
        .dout(dout), .full(full), .empty(empty), .count(count)
    );
    // A commit snapshots everything queued so far, net of an entry leaving this cycle.
    always_comb begin
        pending_d    = commit ? count - CW'(pop) : pending_q - CW'(pop);
        state_d      = state_q;
        frame_done_d = 1'b0;
        case (state_q)
            IDLE:    if (pending_q != '0) state_d = WAIT_VB;
            WAIT_VB: if (vblank) state_d = DRAIN;
            default: begin
                if (pending_d == '0) begin
                    state_d      = IDLE;
                    frame_done_d = pop;
                end else if (!vblank) state_d = WAIT_VB;
            end
        endcase
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            pending_q    <= '0;
            frame_done_q <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            frame_done_q <= frame_done_d;
            wr_en_q      <= pop;
            if (pop) {wr_addr_q, wr_data_q} <= dout;
        end
    end
    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign pending    = pending_q;
    assign frame_done = frame_done_q;
    assert property (@(posedge clk) disable iff (!reset_n) !(empty && pending_q != '0));
endmodule

// File: tb/tb_vblank_write_buffer.sv
// tb_vblank_write_buffer: directed and randomized checks of the vblank write buffer against a stream model.
// Build with VBLANK_WBUF_IRQ_EN defined to also exercise the irq output.
module tb_vblank_write_buffer;
    logic clk = 1'b0, reset_n = 1'b0, chipselect = 1'b0, write = 1'b0;
    logic [15:0] address = '0;
    logic [31:0] writedata = '0;
    logic [9:0]  vcount = '0;
    logic waitrequest, wr_en, frame_done;
    logic [15:0] wr_addr;
    logic [31:0] wr_data;
    logic [6:0]  pending;
`ifdef VBLANK_WBUF_IRQ_EN
    logic irq;
`endif
    int n_chk = 0, n_fail = 0, fd_cnt = 0, bad_vb = 0, cyc = 0, ncom = 0;
    logic vb_prev = 1'b0;
    logic [47:0] pushed[$], obs[$];
    int obs_cyc[$];

    always #10 clk = ~clk;

    vblank_write_buffer dut (
        .clk(clk), .reset_n(reset_n), .chipselect(chipselect), .write(write),
        .address(address), .writedata(writedata), .waitrequest(waitrequest),
        .vcount(vcount), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .pending(pending), .frame_done(frame_done)
`ifdef VBLANK_WBUF_IRQ_EN
        , .irq(irq)
`endif
    );

    // A table write seen now must come from a pop made while vcount was in vblank.
    always @(negedge clk) begin
        cyc++;
        if (wr_en) begin
            obs.push_back({wr_addr, wr_data});
            obs_cyc.push_back(cyc);
            if (!vb_prev) bad_vb++;
        end
        if (frame_done) fd_cnt++;
        vb_prev = vcount >= 10'd480;
    end

    task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
        n_chk++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, o, e);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Every committed write must reach the tables exactly once, in host order.
    task automatic chk_stream(input string tag);
        chk({tag, "_len"}, obs.size(), ncom);
        foreach (obs[i]) if (i < ncom) chk(tag, obs[i], pushed[i]);
    endtask

    task automatic hw(input logic [15:0] a, input logic [31:0] d);
        int n = 0;
        chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
        #1;
        while (waitrequest && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("host_stall_bound", n < 3000, 1);
        @(posedge clk);
        #1;
        chipselect = 1'b0; write = 1'b0;
        if (a == 16'hFFFF) ncom = pushed.size();
`ifdef VBLANK_WBUF_IRQ_EN
        else if (a != 16'hFFFE) pushed.push_back({a, d});
`else
        else pushed.push_back({a, d});
`endif
    endtask

    function automatic logic [15:0] rnd_addr();
        return 16'($urandom_range(0, 16'hFFFD));
    endfunction

    initial begin
        int n, f0, base, k;
        tick(3);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_pending", pending, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_waitrequest", waitrequest, 0);
        reset_n = 1'b1;
        tick(2);
        // Uncommitted writes never reach the tables, even across a whole vblank.
        vcount = 10'd100;
        hw(16'h0001, 32'hAA); hw(16'h1002, 32'hBB); hw(16'h2003, 32'hCC);
        vcount = 10'd480; tick(60); vcount = 10'd100; tick(5);
        chk("nocommit_writes", obs.size(), 0);
        chk("nocommit_pending", pending, 0);
        reset_n = 1'b0; #2; reset_n = 1'b1;
        pushed.delete(); obs.delete(); obs_cyc.delete(); ncom = 0;
        tick(1);
        // Committed batch drains back to back at the start of vblank.
        hw(16'h0001, 32'hAA); hw(16'h1002, 32'hBB); hw(16'h2003, 32'hCC); hw(16'hFFFF, 0);
        tick(3);
        chk("commit_pending", pending, 3);
        chk("commit_no_early_drain", obs.size(), 0);
        f0 = fd_cnt;
        vcount = 10'd480; tick(10);
        chk_stream("burst");
        chk("burst_addr2", obs.size() >= 3 ? obs[2][47:32] : 16'h0, 16'h2003);
        chk("burst_consecutive", obs.size() >= 3 ? obs_cyc[2] - obs_cyc[0] : -1, 2);
        chk("burst_frame_done", fd_cnt - f0, 1);
        chk("burst_pending", pending, 0);
        // Full FIFO stalls the host; the overflow write waits for a drain pop and the next commit.
        vcount = 10'd100;
        for (int i = 0; i < 64; i++) hw(rnd_addr(), $urandom);
        hw(16'hFFFF, 0);
        tick(2);
        chk("full_pending", pending, 64);
        chipselect = 1'b1; write = 1'b1; address = rnd_addr(); writedata = $urandom;
        #1;
        chk("full_wait_now", waitrequest, 1);
        tick(8);
        chk("full_wait_later", waitrequest, 1);
        vcount = 10'd480;
        n = 0;
        while (waitrequest && n < 100) begin tick(1); n++; end
        chk("full_release", n < 100, 1);
        @(posedge clk);
        #1;
        chipselect = 1'b0; write = 1'b0;
        pushed.push_back({address, writedata});
        tick(80);
        chk_stream("full_first");
        chk("full_pending_left", pending, 0);
        hw(16'hFFFF, 0);
        tick(8);
        chk_stream("full_second");
        // Vblank ending mid-batch holds the remainder for the next vblank.
        vcount = 10'd100;
        base = obs.size();
        for (int i = 0; i < 10; i++) hw(rnd_addr(), $urandom);
        hw(16'hFFFF, 0);
        tick(3);
        f0 = fd_cnt;
        vcount = 10'd480;
        for (n = 0; n < 100 && obs.size() < base + 4; n++) begin @(negedge clk); #1; end
        vcount = 10'd0;
        chk("part_wait", n < 100, 1);
        tick(20);
        chk("part_first_frame", obs.size() - base, 4);
        chk("part_pending", pending, 6);
        chk("part_no_frame_done", fd_cnt - f0, 0);
        vcount = 10'd480; tick(20);
        chk("part_second_frame", obs.size() - base, 10);
        chk("part_frame_done", fd_cnt - f0, 1);
        chk_stream("part");
        // Reset mid-drain clears outputs at once and discards everything queued.
        vcount = 10'd100;
        for (int i = 0; i < 8; i++) hw(rnd_addr(), $urandom);
        hw(16'hFFFF, 0);
        tick(3);
        base = obs.size();
        vcount = 10'd480;
        for (n = 0; n < 100 && obs.size() < base + 2; n++) begin @(negedge clk); #1; end
        reset_n = 1'b0;
        #1;
        chk("rst_async_wr_en", wr_en, 0);
        chk("rst_async_pending", pending, 0);
        pushed.delete(); obs.delete(); obs_cyc.delete(); ncom = 0;
        tick(2);
        reset_n = 1'b1;
        tick(30);
        chk("rst_no_stale", obs.size(), 0);
        chk("rst_pending_after", pending, 0);
        // Random batches, with a few writes left uncommitted until the next round's commit.
        for (int r = 0; r < 6; r++) begin
            vcount = 10'($urandom_range(0, 479));
            k = $urandom_range(1, 20);
            for (int i = 0; i < k; i++) hw(rnd_addr(), $urandom);
            hw(16'hFFFF, 0);
            k = $urandom_range(0, 3);
            for (int i = 0; i < k; i++) hw(rnd_addr(), $urandom);
            tick(3);
            vcount = 10'($urandom_range(480, 524));
            tick(40);
            chk("rand_pending", pending, 0);
            vcount = 10'd100;
        end
        chk_stream("rand");
`ifdef VBLANK_WBUF_IRQ_EN
        hw(rnd_addr(), $urandom); hw(16'hFFFF, 0);
        tick(3);
        vcount = 10'd480; tick(20);
        chk("irq_set", irq, 1);
        hw(16'hFFFE, 0);
        chk("irq_clear", irq, 0);
        vcount = 10'd100;
        hw(rnd_addr(), $urandom); hw(16'hFFFF, 0);
        tick(3);
        vcount = 10'd480;
        for (n = 0; n < 100 && !frame_done; n++) @(negedge clk);
        chk("irq_fd_wait", n < 100, 1);
        chipselect = 1'b1; write = 1'b1; address = 16'hFFFE;
        @(posedge clk);
        #1;
        chipselect = 1'b0; write = 1'b0;
        chk("irq_set_wins", irq, 1);
        tick(5);
        chk_stream("irq");
`endif
        chk("writes_only_in_vblank", bad_vb, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/vblank_write_buffer.md
Name: vblank_write_buffer

Overview:
Host-side write staging buffer that sits directly upstream of the PPU's table-write port.
- Accepts Avalon-style host writes and holds them in a FIFO.
- Once the host issues a commit, releases the committed writes to the PPU tables, one per cycle, only during vertical blanking. Tables never change mid-frame, so there is no tearing.
- Replaces direct chipselect/write/address/writedata wiring into the PPU.

Parameters:
DEPTH, 64, FIFO entries (power of 2, ≥4)
AW, 16, host/table address width
DW, 32, data width
VACTIVE, 480, first vcount value treated as vblank
COMMIT_ADDR, 16'hFFFF, host address that acts as the commit fence (never queued)

Ports:
clk  in  1  system clock (50 MHz)
reset_n  in  1  asynchronous active-low reset
chipselect  in  1  host select
write  in  1  host write strobe
address  in  AW  host word address
writedata  in  DW  host data
waitrequest  out  1  stall host; combinational = chipselect & write & full & (address != COMMIT_ADDR)
vcount  in  10  current scanline from vga_counters
wr_en  out  1  one-cycle table write strobe to PPU
wr_addr  out  AW  table address (bits 15:12 select table, as PPU decodes)
wr_data  out  DW  table data
pending  out  $clog2(DEPTH)+1  committed entries not yet drained
frame_done  out  1  one-cycle pulse when a committed batch finishes draining

Behaviour:
- Reset values: wr_en=0, wr_addr=0, wr_data=0, pending=0, frame_done=0, FIFO empty, state=IDLE. Asserting reset mid-drain discards all queued writes.
- Push: on a posedge with chipselect & write & !waitrequest & address≠COMMIT_ADDR, enqueue {address, writedata}.
- Full FIFO: the host stalls on waitrequest; no write is lost.
- Commit: a host write to COMMIT_ADDR is never queued and never stalls.
  - It sets pending to count − (pop this cycle ? 1 : 0).
  - Writes enqueued after the commit stay uncommitted until the next commit.
  - A second commit before draining completes re-snapshots the count, absorbing the newer writes.
- vblank = (vcount ≥ VACTIVE).
- State machine:
  - IDLE: go to WAIT_VB when pending>0.
  - WAIT_VB: go to DRAIN when vblank=1.
  - DRAIN:
    - Each cycle with pending>0 and vblank=1: pop one entry and decrement pending.
    - pending reaches 0: pulse frame_done the next cycle, go to IDLE.
    - vblank drops first: go to WAIT_VB, remaining entries are held for the next frame's vblank.
- Output timing:
  - wr_en/wr_addr/wr_data are registered, asserted the cycle after a pop, with 1 cycle pop→write latency.
  - wr_addr/wr_data hold their last values when wr_en=0.
- Throughput: 1 write/cycle. A 45-line vblank × 1600 cycles covers DEPTH many times over.
- Simultaneous push and pop: count is unchanged; FIFO pointers wrap modulo DEPTH.
- Push to a full FIFO on the same cycle as a pop: still stalled. waitrequest is based on the registered full flag, accepting one cycle of lost throughput.
- Empty FIFO with pending>0: cannot occur by construction; an assertion checks it.

Optional Feature:
VBLANK_WBUF_IRQ_EN
- Defined: adds an output irq (1 bit, reset 0).
  - irq is set on frame_done.
  - irq is cleared by a host write to COMMIT_ADDR−1 (16'hFFFE), which is not queued.
  - Set and clear on the same cycle: set wins.
- Undefined: no irq port; 16'hFFFE is an ordinary queued address.

Decomposition:
- Package ppu_pkg:
  - table base constants (ATTR 4'h0, COLOR 4'h1, PATTERN 4'h2, SPRITE 4'h3)
  - COMMIT_ADDR and IRQ_CLR_ADDR
  - VACTIVE
  - typedef struct packed {logic [15:0] addr; logic [31:0] data;} wbuf_entry_t
  - wbuf_state_t enum {IDLE, WAIT_VB, DRAIN}
- Sub-module sync_fifo (parameterised width/depth, push/pop/full/empty/count) instantiated once. The FSM stays in vblank_write_buffer.

Test Plan:
- Write 3 entries (0x0001/0xAA, 0x1002/0xBB, 0x2003/0xCC) at vcount=100 with no commit → wr_en stays 0 for a full frame; pending=0.
- Same 3 writes, commit at vcount=100 → pending=3; at vcount=480, wr_en pulses on 3 consecutive cycles with entries in order; frame_done pulses once; pending=0.
- Fill 64 entries, 65th write → waitrequest=1 until a drain pop. The 65th entry is committed only by a second commit and appears after the first 64.
- Commit 10 entries, force vcount 480→0 after 4 pops → 4 writes this frame, remaining 6 at next vcount=480, then frame_done.
- Assert reset_n=0 mid-drain → wr_en=0 within 0 cycles (async); pending=0; after release no stale writes appear.
- VBLANK_WBUF_IRQ_EN defined: drain completes → irq=1; write 0xFFFE → irq=0 next cycle; simultaneous frame_done and clear → irq=1.
